// File: rtl/msx_mouse_reader_if.sv
// Port-side bundle for the MSX mouse reader: requester controls and pins in, strobe and decoded report out.
interface msx_mouse_reader_if;
  logic       enable;
  logic       start;
  logic [5:0] pin_in;
  logic       strobe;
  logic       busy;
  logic       valid;
  logic [7:0] dx;
  logic [7:0] dy;
  logic [1:0] buttons;
  logic [9:0] pos_x;
  logic [9:0] pos_y;

  modport master (
    output enable, start, pin_in,
    input  strobe, busy, valid, dx, dy, buttons, pos_x, pos_y
  );

  modport slave (
    input  enable, start, pin_in,
    output strobe, busy, valid, dx, dy, buttons, pos_x, pos_y
  );
endinterface

// File: rtl/msx_mouse_reader.sv
// MSX mouse initiator: four strobe toggles per read, one nibble sampled per toggle, report flagged by a one-cycle valid.
// Optional position accumulator enabled by MSX_MOUSE_READER_ACCUM_EN; valid lands 4*NIBBLE_WAIT+5 cycles after the start cycle.
module msx_mouse_reader #(
  parameter int NIBBLE_WAIT = 2100,
  parameter int GAP_CYCLES  = 420000
) (
  input logic               clk_sys,
  input logic               reset_n,
  msx_mouse_reader_if.slave bus
);

  localparam int CNT_MAX = (GAP_CYCLES > NIBBLE_WAIT) ? GAP_CYCLES : NIBBLE_WAIT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] NIB_RELOAD = CW'(NIBBLE_WAIT - 1);
  localparam logic [CW-1:0] GAP_RELOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_GAP} state_t;

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [5:0]    pin_meta_q;
  logic [5:0]    pin_sync_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [11:0]   nib_q;
  logic          strobe_q;
  logic          busy_q;
  logic          valid_q;
  logic [7:0]    dx_q;
  logic [7:0]    dy_q;
  logic [1:0]    buttons_q;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pin_meta_q <= '1;
      pin_sync_q <= '1;
    end else begin
      pin_meta_q <= bus.pin_in;
      pin_sync_q <= pin_meta_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      nib_q     <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      buttons_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start || bus.enable) begin
            strobe_q <= ~strobe_q;
            cnt_q    <= NIB_RELOAD;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_q <= S_CAPTURE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_CAPTURE: begin
          // nib_q holds nibbles 0..2 oldest-first; the fourth comes straight from the pins.
          nib_q <= {nib_q[7:0], pin_sync_q[3:0]};
          if (idx_q != 2'd3) begin
            idx_q    <= idx_q + 2'd1;
            strobe_q <= ~strobe_q;
            cnt_q    <= NIB_RELOAD;
            state_q  <= S_SETTLE;
          end else begin
            dx_q      <= nib_q[11:4];
            dy_q      <= {nib_q[3:0], pin_sync_q[3:0]};
            buttons_q <= ~pin_sync_q[5:4];
            valid_q   <= 1'b1;
            cnt_q     <= GAP_RELOAD;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.strobe  = strobe_q;
  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.dx      = dx_q;
  assign bus.dy      = dy_q;
  assign bus.buttons = buttons_q;

`ifdef MSX_MOUSE_READER_ACCUM_EN
  logic [9:0] pos_x_q, pos_y_q;
  logic [9:0] pos_x_d, pos_y_d;

  function automatic logic [9:0] sat_add(input logic [9:0] pos, input logic [7:0] delta);
    logic signed [11:0] sum;
    sum = $signed({2'b00, pos}) + $signed({{4{delta[7]}}, delta});
    if (sum < 12'sd0)         sat_add = 10'd0;
    else if (sum > 12'sd1023) sat_add = 10'd1023;
    else                      sat_add = sum[9:0];
  endfunction

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (valid_q) begin
      pos_x_d = sat_add(pos_x_q, dx_q);
      pos_y_d = sat_add(pos_y_q, dy_q);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q <= 10'd512;
      pos_y_q <= 10'd512;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  assign bus.pos_x = pos_x_q;
  assign bus.pos_y = pos_y_q;
`else
  assign bus.pos_x = '0;
  assign bus.pos_y = '0;
`endif

endmodule
